// File: rtl/mdriver_arbiter_pkg.sv
// rtl/mdriver_arbiter_pkg.sv - shared types and helpers for the master-driver arbiter
package mdriver_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    BUSY  = 2'd2,
    DONE  = 2'd3
  } arb_state_t;

  // Width of an index able to address n requesters (never less than one bit)
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mdriver_arbiter_rr_pick.sv
// rtl/mdriver_arbiter_rr_pick.sv - combinational round-robin winner picker
module rr_pick
  import mdriver_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IW      = idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      last_grant,
  output logic               any,
  output logic [IW-1:0]      idx
);

  int cand;

  // Scan from the lowest priority (last_grant itself) up to last_grant+1 so the
  // final assignment that sticks is the closest requester after last_grant.
  always_comb begin
    any  = |req;
    idx  = '0;
    cand = 0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = int'(last_grant) + k;
      if (cand >= NUM_REQ) begin
        cand = cand - NUM_REQ;
      end
      if (req[cand[IW-1:0]]) begin
        idx = cand[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/mdriver_arbiter.sv
// rtl/mdriver_arbiter.sv - round-robin arbiter sharing one master driver port; optional watchdog via MDRIVER_ARB_TIMEOUT_EN
module mdriver_arbiter
  import mdriver_arb_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_exec,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        req_fin,
  output logic [NUM_REQ-1:0]        req_err,
  output logic [DATA_W-1:0]         req_rdata,
  output logic                      m_exec,
  output logic                      m_we,
  output logic [ADDR_W-1:0]         m_address,
  output logic [DATA_W-1:0]         m_wdata,
  input  logic [DATA_W-1:0]         m_rdata,
  input  logic                      m_fin
);

  localparam int IW = idx_w(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 16 || TIMEOUT_CYCLES < 2) begin : g_bad_params
    $error("mdriver_arbiter: NUM_REQ must be 2..16 and TIMEOUT_CYCLES at least 2");
  end

  arb_state_t        state;
  arb_state_t        state_nxt;
  logic [IW-1:0]     last_grant;
  logic [IW-1:0]     grant_idx;
  logic              pick_any;
  logic [IW-1:0]     pick_idx;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              timed_out;
  logic              err_q;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_pick (
    .req        (req_exec),
    .last_grant (last_grant),
    .any        (pick_any),
    .idx        (pick_idx)
  );

  // Route the picked requester's command fields towards the latch
  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_idx == IW'(i)) begin
        sel_we    = req_we[i];
        sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
        sel_wdata = req_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

`ifdef MDRIVER_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES);

  logic [CW-1:0] busy_cnt;

  assign timed_out = (state == BUSY) && !m_fin && (busy_cnt == CW'(TIMEOUT_CYCLES - 1));

  // Watchdog: cleared while issuing, counts every BUSY cycle until the job ends
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_cnt <= '0;
    end else if (state == ISSUE) begin
      busy_cnt <= '0;
    end else if (state == BUSY && !m_fin && !timed_out) begin
      busy_cnt <= busy_cnt + 1'b1;
    end
  end

  // Remember whether the current job ended by watchdog rather than by m_fin
  always_ff @(posedge clk) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if (state == ISSUE) begin
      err_q <= 1'b0;
    end else if (timed_out) begin
      err_q <= 1'b1;
    end
  end
`else
  assign timed_out = 1'b0;
  assign err_q     = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: arbitrate only in IDLE, one issue cycle, wait, report
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (pick_any) state_nxt = ISSUE;
      ISSUE:   state_nxt = BUSY;
      BUSY:    if (m_fin || timed_out) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Command latch, read-data capture and round-robin pointer update
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= IW'(NUM_REQ - 1);
      grant_idx  <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (pick_any) begin
            grant_idx <= pick_idx;
            we_q      <= sel_we;
            addr_q    <= sel_addr;
            wdata_q   <= sel_wdata;
          end
        end
        BUSY: begin
          if (m_fin && !we_q) begin
            rdata_q <= m_rdata;
          end
        end
        DONE: begin
          last_grant <= grant_idx;
        end
        default: ;
      endcase
    end
  end

  // Driver-side outputs follow the latched command; exec only in ISSUE
  always_comb begin
    m_exec    = (state == ISSUE);
    m_we      = we_q;
    m_address = addr_q;
    m_wdata   = wdata_q;
  end

  // Requester-side completion: one-hot fin/err and gated read data in DONE
  always_comb begin
    req_fin = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_fin[i] = (state == DONE) && (grant_idx == IW'(i));
    end
    req_err   = req_fin & {NUM_REQ{err_q}};
    req_rdata = (state == DONE && !err_q) ? rdata_q : '0;
  end

endmodule
